// File: rtl/stream_serializer_arbiter.sv
// stream_serializer_arbiter: round-robin arbiter feeding one shared word-to-beat serializer.
// Define STREAM_ARB_PACKET_LOCK_EN to hold the grant on one requester until its eof word is taken.
module stream_serializer_arbiter #(
    parameter int NumInputs = 2,
    parameter int DataBits = 8,
    parameter int Ratio = 2,
    localparam int SelBits = $clog2(NumInputs),
    localparam int WordBits = Ratio * DataBits
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NumInputs-1:0]          in_valid,
    output logic [NumInputs-1:0]          in_ready,
    input  logic [NumInputs*WordBits-1:0] in_data,
    input  logic [NumInputs-1:0]          in_eof,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DataBits-1:0]           out_data,
    output logic                          out_eof,
    output logic [SelBits-1:0]            out_sel
);
    localparam int CntBits = Ratio > 1 ? $clog2(Ratio) : 1;

    typedef enum logic {IDLE, SERIAL} state_t;

    state_t state, state_next;
    logic [WordBits-1:0] word;
    logic [CntBits-1:0] cnt;
    logic word_eof;
    logic [SelBits-1:0] ptr, win, win_next, cand;
    logic [SelBits:0] sum;
    logic [NumInputs-1:0] req;
    logic found, last_beat, last_hs, grant;
`ifdef STREAM_ARB_PACKET_LOCK_EN
    logic lock;

    // while a packet is open only its owner (still held in out_sel) may compete
    assign req = lock ? in_valid & (NumInputs'(1) << out_sel) : in_valid;
`else
    assign req = in_valid;
`endif

    assign last_beat = cnt == CntBits'(Ratio - 1);
    assign out_valid = state == SERIAL;
    assign last_hs = out_valid && out_ready && last_beat;
    assign out_data = word[DataBits-1:0];
    assign out_eof = out_valid && word_eof && last_beat;
    assign grant = !rst && found && (state == IDLE || last_hs);
    assign in_ready = grant ? NumInputs'(1) << win : '0;
    assign win_next = win == SelBits'(NumInputs - 1) ? '0 : win + 1'b1;

    // descending scan so the candidate nearest the pointer is the last one written
    always_comb begin
        found = 1'b0;
        win = '0;
        sum = '0;
        cand = '0;
        for (int i = NumInputs - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (SelBits + 1)'(i);
            sum = sum >= (SelBits + 1)'(NumInputs) ? sum - (SelBits + 1)'(NumInputs) : sum;
            cand = sum[SelBits-1:0];
            if (req[cand]) begin
                found = 1'b1;
                win = cand;
            end
        end
    end

    always_comb begin
        state_next = grant ? SERIAL : last_hs ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
            cnt <= '0;
            word_eof <= 1'b0;
            out_sel <= '0;
            ptr <= '0;
`ifdef STREAM_ARB_PACKET_LOCK_EN
            lock <= 1'b0;
`endif
        end else if (grant) begin
            word <= in_data[int'(win) * WordBits +: WordBits];
            word_eof <= in_eof[win];
            out_sel <= win;
            cnt <= '0;
`ifdef STREAM_ARB_PACKET_LOCK_EN
            lock <= !in_eof[win];
            if (in_eof[win]) ptr <= win_next;
`else
            ptr <= win_next;
`endif
        end else if (out_valid && out_ready && !last_beat) begin
            word <= word >> DataBits;
            cnt <= cnt + 1'b1;
        end
    end
endmodule
